// File: rtl/laser_host.sv
// Driving end of the LASER point-cover protocol: loads a 40-point pattern, resets and
// feeds LASER, waits for DONE (or a timeout) and scores how many points the centres cover.
module laser_host #(
  parameter int NPTS    = 40,
  parameter int R2      = 16,
  parameter int MAX_CYC = 50000,
  parameter int RST_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD_EN,
  input  logic [5:0]  LD_ADDR,
  input  logic [3:0]  LD_X,
  input  logic [3:0]  LD_Y,
  input  logic        START,
  output logic        LASER_RST,
  output logic [3:0]  X,
  output logic [3:0]  Y,
  input  logic [3:0]  C1X,
  input  logic [3:0]  C1Y,
  input  logic [3:0]  C2X,
  input  logic [3:0]  C2Y,
  input  logic        DONE,
  output logic        BUSY,
  output logic        RES_VALID,
  output logic [5:0]  COVER,
  output logic [15:0] CYCLES,
  output logic        TIMEOUT,
  output logic        ERR,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RSTL  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_SCORE = 3'd4;

  localparam logic [5:0]  LAST_PT  = 6'(NPTS - 1);
  localparam logic [5:0]  LAST_RST = 6'(RST_CYC - 1);
  localparam logic [15:0] LAST_CYC = 16'(MAX_CYC - 1);
  localparam logic [8:0]  R2_V     = 9'(R2);

  logic [2:0] state;
  logic [5:0] cnt;
  logic [5:0] rd_addr;
  logic [3:0] mem_x [NPTS];
  logic [3:0] mem_y [NPTS];
  logic [3:0] px, py;
  logic [3:0] c1x_q, c1y_q, c2x_q, c2y_q;
  logic [8:0] d1, d2;
  logic       covered;

  // Squared Euclidean distance from 5-bit two's-complement differences (-15..15).
  function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                       input logic [3:0] bx, input logic [3:0] by);
    logic [4:0] dx, dy;
    logic [3:0] mag_x, mag_y;
    logic [7:0] sq_x, sq_y;
    dx    = {1'b0, ax} - {1'b0, bx};
    dy    = {1'b0, ay} - {1'b0, by};
    mag_x = dx[4] ? 4'(-dx) : dx[3:0];
    mag_y = dy[4] ? 4'(-dy) : dy[3:0];
    sq_x  = {4'b0, mag_x} * {4'b0, mag_x};
    sq_y  = {4'b0, mag_y} * {4'b0, mag_y};
    return {1'b0, sq_x} + {1'b0, sq_y};
  endfunction

  // One read port: SEND prefetches the next point, RSTL preloads point 0, SCORE reads cnt.
  always_comb begin
    rd_addr = cnt;
    if (state == S_SEND) rd_addr = cnt + 6'd1;
    else if (state == S_RSTL) rd_addr = 6'd0;
  end

  assign px      = mem_x[rd_addr];
  assign py      = mem_y[rd_addr];
  assign d1      = dist2(px, py, c1x_q, c1y_q);
  assign d2      = dist2(px, py, c2x_q, c2y_q);
  assign covered = (d1 <= R2_V) || (d2 <= R2_V);

  assign LASER_RST = (state == S_IDLE) || (state == S_RSTL);
  assign BUSY      = (state != S_IDLE);
  assign dbg_state = state;

  // Point memory survives reset so a pattern can be rerun after an abort.
  always_ff @(posedge CLK) begin
    if (LD_EN && (state == S_IDLE) && (LD_ADDR <= LAST_PT)) begin
      mem_x[LD_ADDR] <= LD_X;
      mem_y[LD_ADDR] <= LD_Y;
    end
  end

  // DONE is a level from LASER sampled each cycle; RES_VALID is a one-cycle strobe with
  // COVER/CYCLES/TIMEOUT/ERR held stable from that cycle until the next accepted START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      X         <= 4'd0;
      Y         <= 4'd0;
      COVER     <= 6'd0;
      CYCLES    <= 16'd0;
      TIMEOUT   <= 1'b0;
      ERR       <= 1'b0;
      RES_VALID <= 1'b0;
      c1x_q     <= 4'd0;
      c1y_q     <= 4'd0;
      c2x_q     <= 4'd0;
      c2y_q     <= 4'd0;
    end else begin
      RES_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && !LD_EN) begin
            COVER   <= 6'd0;
            CYCLES  <= 16'd0;
            TIMEOUT <= 1'b0;
            ERR     <= 1'b0;
            cnt     <= 6'd0;
            state   <= S_RSTL;
          end
        end
        S_RSTL: begin
          if (cnt == LAST_RST) begin
            cnt   <= 6'd0;
            X     <= px;
            Y     <= py;
            state <= S_SEND;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_SEND: begin
          if (DONE) begin
            ERR       <= 1'b1;
            RES_VALID <= 1'b1;
            cnt       <= 6'd0;
            state     <= S_IDLE;
          end else if (cnt == LAST_PT) begin
            cnt   <= 6'd0;
            state <= S_RUN;
          end else begin
            X   <= px;
            Y   <= py;
            cnt <= cnt + 6'd1;
          end
        end
        S_RUN: begin
          if (DONE) begin
            c1x_q <= C1X;
            c1y_q <= C1Y;
            c2x_q <= C2X;
            c2y_q <= C2Y;
            state <= S_SCORE;
          end else begin
            if (CYCLES != 16'hFFFF) CYCLES <= CYCLES + 16'd1;
            if (CYCLES >= LAST_CYC) begin
              c1x_q   <= C1X;
              c1y_q   <= C1Y;
              c2x_q   <= C2X;
              c2y_q   <= C2Y;
              TIMEOUT <= 1'b1;
              state   <= S_SCORE;
            end
          end
        end
        S_SCORE: begin
          COVER <= COVER + 6'(covered);
          if (cnt == LAST_PT) begin
            RES_VALID <= 1'b1;
            cnt       <= 6'd0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// Bench for laser_host: plays the LASER side, checks the point stream, result timing and
// the cover count against a direct distance-counting model of the loaded pattern.
module tb_laser_host;
  localparam int NPTS       = 40;
  localparam int MAX_CYC_TB = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b0, LD_EN = 1'b0, START = 1'b0, DONE = 1'b0;
  logic [5:0]  LD_ADDR = 6'd0;
  logic [3:0]  LD_X = 4'd0, LD_Y = 4'd0;
  logic [3:0]  C1X = 4'd0, C1Y = 4'd0, C2X = 4'd0, C2Y = 4'd0;
  logic        LASER_RST, BUSY, RES_VALID, TIMEOUT, ERR;
  logic [3:0]  X, Y;
  logic [5:0]  COVER;
  logic [15:0] CYCLES;
  logic [2:0]  dbg_state;

  int checks = 0, errors = 0;
  int mx [NPTS];
  int my [NPTS];
  int r_rst, r_xy, r_lat, r_pulses;

  laser_host #(.MAX_CYC(MAX_CYC_TB)) dut (
    .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_X(LD_X), .LD_Y(LD_Y),
    .START(START), .LASER_RST(LASER_RST), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .BUSY(BUSY), .RES_VALID(RES_VALID), .COVER(COVER), .CYCLES(CYCLES),
    .TIMEOUT(TIMEOUT), .ERR(ERR), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Count points within radius^2 16 of either centre.
  function automatic int model_cover(input int ax, input int ay, input int bx, input int by);
    int n = 0;
    for (int i = 0; i < NPTS; i++) begin
      int da, db;
      da = (mx[i] - ax) * (mx[i] - ax) + (my[i] - ay) * (my[i] - ay);
      db = (mx[i] - bx) * (mx[i] - bx) + (my[i] - by) * (my[i] - by);
      if (da <= 16 || db <= 16) n++;
    end
    return n;
  endfunction

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic load_point(input int a, input int x, input int y);
    @(negedge CLK);
    LD_EN = 1'b1; LD_ADDR = 6'(a); LD_X = 4'(x); LD_Y = 4'(y);
    mx[a] = x; my[a] = y;
    @(negedge CLK);
    LD_EN = 1'b0;
  endtask

  task automatic garbage_centres();
    C1X = 4'($urandom_range(0, 15)); C1Y = 4'($urandom_range(0, 15));
    C2X = 4'($urandom_range(0, 15)); C2Y = 4'($urandom_range(0, 15));
  endtask

  // LASER side of one run. done_at: RUN cycle index where DONE rises (-1 = never).
  // err_at: SEND cycle where DONE rises (-1 = none). poke: drive LD_EN/START while busy.
  task automatic run_laser(input int done_at, input int err_at, input int c1x, input int c1y,
                           input int c2x, input int c2y, input bit poke);
    int lat_j, guard;
    bit aborted;
    r_rst = 0; r_xy = 0; r_lat = -1; r_pulses = 0; aborted = 1'b0;
    lat_j = (done_at >= 0) ? done_at : MAX_CYC_TB - 1;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    guard = 0;
    while (LASER_RST === 1'b1 && guard < 20) begin
      r_rst++; guard++;
      @(negedge CLK);
    end
    for (int k = 0; k < NPTS && !aborted; k++) begin
      if (X !== 4'(mx[k]) || Y !== 4'(my[k])) r_xy++;
      garbage_centres();
      if (poke) begin
        LD_EN = 1'b1; LD_ADDR = 6'(k); LD_X = ~4'(mx[k]); LD_Y = ~4'(my[k]); START = 1'b1;
      end
      if (k == err_at) begin DONE = 1'b1; aborted = 1'b1; end
      @(negedge CLK);
    end
    if (!aborted) begin
      for (int j = 0; j <= lat_j; j++) begin
        LD_EN = 1'b0; START = 1'b0;
        if (j == lat_j) begin
          C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
          DONE = (done_at >= 0);
        end else begin
          garbage_centres();
        end
        @(negedge CLK);
      end
    end
    for (int n = 1; n <= 60; n++) begin
      DONE = 1'b0; LD_EN = 1'b0; START = 1'b0;
      garbage_centres();
      if (RES_VALID === 1'b1) begin
        r_pulses++;
        if (r_lat < 0) r_lat = n;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (LASER_RST !== 1'b1) begin errors++; $display("FAIL reset_laser_rst: got %b want 1", LASER_RST); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (RES_VALID !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", RES_VALID); end
    checks++; if (COVER !== 6'd0 || CYCLES !== 16'd0) begin errors++; $display("FAIL reset_counts: got cover %0d cycles %0d want 0 0", COVER, CYCLES); end
    checks++; if (TIMEOUT !== 1'b0 || ERR !== 1'b0) begin errors++; $display("FAIL reset_flags: got timeout %b err %b want 0 0", TIMEOUT, ERR); end
    checks++; if (X !== 4'd0 || Y !== 4'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", X, Y); end
  endtask

  task automatic test_all_centre();
    for (int i = 0; i < NPTS; i++) load_point(i, 8, 8);
    run_laser(5, -1, 8, 8, 8, 8, 1'b0);
    checks++; if (r_rst != 2) begin errors++; $display("FAIL centre_rst_cycles: got %0d want 2", r_rst); end
    checks++; if (r_xy != 0) begin errors++; $display("FAIL centre_stream: got %0d bad points want 0", r_xy); end
    checks++; if (COVER !== 6'd40) begin errors++; $display("FAIL centre_cover: got %0d want 40", COVER); end
    checks++; if (CYCLES !== 16'd5) begin errors++; $display("FAIL centre_cycles: got %0d want 5", CYCLES); end
    checks++; if (TIMEOUT !== 1'b0 || ERR !== 1'b0) begin errors++; $display("FAIL centre_flags: got timeout %b err %b want 0 0", TIMEOUT, ERR); end
    checks++; if (r_pulses != 1) begin errors++; $display("FAIL centre_pulses: got %0d want 1", r_pulses); end
    checks++; if (r_lat != NPTS + 1) begin errors++; $display("FAIL centre_latency: got %0d want %0d", r_lat, NPTS + 1); end
    checks++; if (BUSY !== 1'b0 || LASER_RST !== 1'b1) begin errors++; $display("FAIL centre_idle: got busy %b laser_rst %b want 0 1", BUSY, LASER_RST); end
  endtask

  task automatic test_two_groups();
    for (int i = 0; i < NPTS; i++) load_point(i, (i < 20) ? 0 : 15, (i < 20) ? 0 : 15);
    run_laser($urandom_range(1, 20), -1, 2, 2, 12, 15, 1'b0);
    checks++; if (COVER !== 6'd40) begin errors++; $display("FAIL groups_cover_both: got %0d want 40", COVER); end
    run_laser(0, -1, 2, 2, 10, 10, 1'b0);
    checks++; if (COVER !== 6'd20) begin errors++; $display("FAIL groups_cover_one: got %0d want 20", COVER); end
    checks++; if (CYCLES !== 16'd0) begin errors++; $display("FAIL groups_first_cycle_done: got %0d want 0", CYCLES); end
    checks++; if (r_pulses != 1 || r_lat != NPTS + 1) begin errors++; $display("FAIL groups_pulse: got %0d pulses lat %0d want 1 %0d", r_pulses, r_lat, NPTS + 1); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NPTS; i++) load_point(i, 15, 15);
    load_point(0, 4, 0);
    load_point(1, 4, 1);
    load_point(2, 0, 3);
    load_point(3, 0, 10);
    load_point(4, 1, 10);
    run_laser(3, -1, 0, 0, 0, 6, 1'b0);
    checks++; if (COVER !== 6'd3) begin errors++; $display("FAIL boundary_cover: got %0d want 3", COVER); end
    checks++; if (COVER !== 6'(model_cover(0, 0, 0, 6))) begin errors++; $display("FAIL boundary_model: got %0d want %0d", COVER, model_cover(0, 0, 0, 6)); end
    run_laser(2, -1, 15, 15, 0, 0, 1'b0);
    checks++; if (COVER !== 6'(model_cover(15, 15, 0, 0))) begin errors++; $display("FAIL boundary_extremes: got %0d want %0d", COVER, model_cover(15, 15, 0, 0)); end
  endtask

  task automatic test_err_in_send();
    run_laser(-1, 10, 8, 8, 8, 8, 1'b0);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", ERR); end
    checks++; if (COVER !== 6'd0) begin errors++; $display("FAIL err_cover: got %0d want 0", COVER); end
    checks++; if (r_lat != 1 || r_pulses != 1) begin errors++; $display("FAIL err_pulse: got lat %0d pulses %0d want 1 1", r_lat, r_pulses); end
    checks++; if (TIMEOUT !== 1'b0 || CYCLES !== 16'd0) begin errors++; $display("FAIL err_other: got timeout %b cycles %0d want 0 0", TIMEOUT, CYCLES); end
    checks++; if (r_xy != 0) begin errors++; $display("FAIL err_stream: got %0d bad points want 0", r_xy); end
  endtask

  task automatic test_timeout();
    int cx1, cy1, cx2, cy2;
    for (int i = 0; i < NPTS; i++) load_point(i, $urandom_range(0, 15), $urandom_range(0, 15));
    cx1 = $urandom_range(0, 15); cy1 = $urandom_range(0, 15);
    cx2 = $urandom_range(0, 15); cy2 = $urandom_range(0, 15);
    run_laser(-1, -1, cx1, cy1, cx2, cy2, 1'b0);
    checks++; if (TIMEOUT !== 1'b1 || ERR !== 1'b0) begin errors++; $display("FAIL timeout_flags: got timeout %b err %b want 1 0", TIMEOUT, ERR); end
    checks++; if (CYCLES !== 16'(MAX_CYC_TB)) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", CYCLES, MAX_CYC_TB); end
    checks++; if (COVER !== 6'(model_cover(cx1, cy1, cx2, cy2))) begin errors++; $display("FAIL timeout_cover: got %0d want %0d", COVER, model_cover(cx1, cy1, cx2, cy2)); end
    checks++; if (r_pulses != 1 || r_lat != NPTS + 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses lat %0d want 1 %0d", r_pulses, r_lat, NPTS + 1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < NPTS; i++) load_point(i, $urandom_range(0, 15), $urandom_range(0, 15));
    for (int it = 0; it < 3; it++) begin
      int cx1, cy1, cx2, cy2, d;
      cx1 = $urandom_range(0, 15); cy1 = $urandom_range(0, 15);
      cx2 = $urandom_range(0, 15); cy2 = $urandom_range(0, 15);
      d = $urandom_range(0, 30);
      run_laser(d, -1, cx1, cy1, cx2, cy2, it == 0);
      checks++; if (r_xy != 0) begin errors++; $display("FAIL random_stream[%0d]: got %0d bad points want 0", it, r_xy); end
      checks++; if (COVER !== 6'(model_cover(cx1, cy1, cx2, cy2))) begin errors++; $display("FAIL random_cover[%0d]: got %0d want %0d", it, COVER, model_cover(cx1, cy1, cx2, cy2)); end
      checks++; if (CYCLES !== 16'(d)) begin errors++; $display("FAIL random_cycles[%0d]: got %0d want %0d", it, CYCLES, d); end
      checks++; if (r_pulses != 1) begin errors++; $display("FAIL random_pulses[%0d]: got %0d want 1", it, r_pulses); end
    end
  endtask

  task automatic test_load_with_start();
    @(negedge CLK);
    LD_EN = 1'b1; LD_ADDR = 6'd5; LD_X = 4'd3; LD_Y = 4'd12; START = 1'b1;
    mx[5] = 3; my[5] = 12;
    @(negedge CLK);
    LD_EN = 1'b0; START = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ldstart_ignored: got busy %b want 0", BUSY); end
    run_laser(4, -1, 3, 12, 0, 0, 1'b0);
    checks++; if (r_xy != 0) begin errors++; $display("FAIL ldstart_written: got %0d bad points want 0", r_xy); end
  endtask

  task automatic test_rst_mid_send();
    int cnt_rv, cnt_busy;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (17) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (BUSY !== 1'b0 || LASER_RST !== 1'b1) begin errors++; $display("FAIL abort_idle: got busy %b laser_rst %b want 0 1", BUSY, LASER_RST); end
    checks++; if (COVER !== 6'd0 || CYCLES !== 16'd0 || X !== 4'd0) begin errors++; $display("FAIL abort_outputs: got cover %0d cycles %0d x %0d want 0 0 0", COVER, CYCLES, X); end
    cnt_rv = 0; cnt_busy = 0;
    for (int n = 0; n < 120; n++) begin
      if (RES_VALID === 1'b1) cnt_rv++;
      if (BUSY === 1'b1) cnt_busy++;
      @(negedge CLK);
    end
    checks++; if (cnt_rv != 0 || cnt_busy != 0) begin errors++; $display("FAIL abort_quiet: got %0d pulses %0d busy cycles want 0 0", cnt_rv, cnt_busy); end
    run_laser(7, -1, 5, 5, 10, 2, 1'b0);
    checks++; if (r_xy != 0) begin errors++; $display("FAIL abort_rerun_stream: got %0d bad points want 0", r_xy); end
    checks++; if (COVER !== 6'(model_cover(5, 5, 10, 2))) begin errors++; $display("FAIL abort_rerun_cover: got %0d want %0d", COVER, model_cover(5, 5, 10, 2)); end
  endtask

  initial begin
    test_reset();
    test_all_centre();
    test_two_groups();
    test_boundary();
    test_err_in_send();
    test_timeout();
    test_random();
    test_load_with_start();
    test_rst_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
